adc_spi_ctrl: RTL and testbench

Parametrised controller for a serial touch-panel ADC (ADS7843-class).
- Waits for pen-down, then runs one SPI conversion per channel: NUM_CH channels, DATA_W-bit results.
- Presents each result with a valid strobe, and repeats while the pen stays down.
- Sits between the touch-panel pins and the coordinate-processing logic. It replaces the single-shot transfer sequencer: it generates DCLK, DIN and CS itself and supports multiple channels and auto-repeat.

---
 rtl/adc_spi_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_adc_spi_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_ctrl.sv
// rtl/adc_spi_ctrl.sv - multi-channel auto-repeat SPI controller for an ADS7843-class touch ADC
//
// Waits for pen-down, then converts NUM_CH channels per frame (one CS_n
// window per channel), presents each DATA_W-bit result with a one-cycle
// strobe, and repeats after a GAP_CYC idle gap while the pen stays down.
//
// Ports:
//   CLK, RST_n     system clock (rising edge), asynchronous active-low reset
//   Enable         run enable; a drop mid-frame finishes the current channel only
//   ADC_PENIRQ_n   pen interrupt from the panel, active low, asynchronous
//   ADC_DOUT       serial result from the ADC
//   ADC_DIN        serial command to the ADC
//   ADC_DCLK       serial clock, half-period CLK_DIV cycles
//   ADC_CS_n       ADC chip select, active low
//   Busy           high while a channel sequence is in progress
//   Data_out       last converted value, held until the next Data_valid
//   Ch_out         channel index of Data_out
//   Data_valid     one-cycle strobe per channel result
//   Frame_done     one-cycle strobe with the last channel's Data_valid

module adc_spi_ctrl #(
  parameter int          DATA_W  = 12,
  parameter int          NUM_CH  = 2,
  parameter logic [11:0] CH_ADDR = 12'b000_000_001_101,
  parameter int          CLK_DIV = 4,
  parameter int          GAP_CYC = 1000
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              Enable,
  input  logic              ADC_PENIRQ_n,
  input  logic              ADC_DOUT,
  output logic              ADC_DIN,
  output logic              ADC_DCLK,
  output logic              ADC_CS_n,
  output logic              Busy,
  output logic [DATA_W-1:0] Data_out,
  output logic [1:0]        Ch_out,
  output logic              Data_valid,
  output logic              Frame_done
);

  localparam int NBITS   = 9 + DATA_W;
  localparam logic MODE  = (DATA_W == 8) ? 1'b1 : 1'b0;
  localparam int CNT_MAX = (GAP_CYC > CLK_DIV) ? GAP_CYC : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(NBITS + 1);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [BIT_W-1:0] BIT_BUSY = BIT_W'(8);
  localparam logic [1:0]       CH_LAST  = 2'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_DESEL,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [1:0]          ch_q, ch_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic                pen_s1, pen_s2;

  logic                dclk_d, din_d, cs_n_d, busy_d, valid_d, frame_d;
  logic [DATA_W-1:0]   data_d;
  logic [1:0]          ch_out_d;
  logic [7:0]          cmd_cur, cmd_sh;

  // {start, A2..A0, MODE, differential, PD1..PD0}
  function automatic logic [7:0] cmd_byte(input logic [1:0] c);
    return {1'b1, CH_ADDR[3*c +: 3], MODE, 1'b0, 2'b00};
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    ch_d     = ch_q;
    sr_d     = sr_q;
    dclk_d   = ADC_DCLK;
    din_d    = ADC_DIN;
    cs_n_d   = ADC_CS_n;
    data_d   = Data_out;
    ch_out_d = Ch_out;
    valid_d  = 1'b0;
    frame_d  = 1'b0;
    cmd_cur  = cmd_byte(ch_q);
    // Bit presented after the falling edge that ends period bit_q;
    // shifting past bit 0 yields the trailing zeros.
    cmd_sh   = cmd_cur << (bit_q + 1'b1);

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        cs_n_d = 1'b1;
        dclk_d = 1'b0;
        din_d  = 1'b0;
        if (Enable && !pen_s2) begin
          state_d = S_CS_SETUP;
          ch_d    = 2'd0;
          cs_n_d  = 1'b0;
          din_d   = 1'b1;  // command start bit
        end
      end

      S_CS_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          dclk_d  = 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (ADC_DCLK) begin
            dclk_d = 1'b0;
            din_d  = cmd_sh[7];
          end else if (bit_q == BIT_LAST) begin
            state_d = S_CS_HOLD;
          end else begin
            bit_d  = bit_q + 1'b1;
            dclk_d = 1'b1;
            // Rising edge of period bit_q+1; periods past the busy bit carry data.
            if (bit_q >= BIT_BUSY)
              sr_d = {sr_q[DATA_W-2:0], ADC_DOUT};
          end
        end
      end

      S_CS_HOLD: begin
        dclk_d = 1'b0;
        if (cnt_q == DIV_LAST) begin
          state_d  = S_DESEL;
          cnt_d    = '0;
          cs_n_d   = 1'b1;
          valid_d  = 1'b1;
          data_d   = sr_q;
          ch_out_d = ch_q;
          frame_d  = (ch_q == CH_LAST);
        end
      end

      S_DESEL: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (ch_q != CH_LAST && Enable) begin
            state_d = S_CS_SETUP;
            ch_d    = ch_q + 2'd1;
            cs_n_d  = 1'b0;
            din_d   = 1'b1;
          end else if (ch_q == CH_LAST && Enable) begin
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_GAP: begin
        if (!Enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!pen_s2) begin
            state_d = S_CS_SETUP;
            ch_d    = 2'd0;
            cs_n_d  = 1'b0;
            din_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        cs_n_d  = 1'b1;
        dclk_d  = 1'b0;
        din_d   = 1'b0;
      end
    endcase

    busy_d = !(state_d == S_IDLE || state_d == S_GAP);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      ch_q       <= 2'd0;
      sr_q       <= '0;
      pen_s1     <= 1'b1;
      pen_s2     <= 1'b1;
      ADC_DCLK   <= 1'b0;
      ADC_DIN    <= 1'b0;
      ADC_CS_n   <= 1'b1;
      Busy       <= 1'b0;
      Data_out   <= '0;
      Ch_out     <= 2'd0;
      Data_valid <= 1'b0;
      Frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ch_q       <= ch_d;
      sr_q       <= sr_d;
      pen_s1     <= ADC_PENIRQ_n;
      pen_s2     <= pen_s1;
      ADC_DCLK   <= dclk_d;
      ADC_DIN    <= din_d;
      ADC_CS_n   <= cs_n_d;
      Busy       <= busy_d;
      Data_out   <= data_d;
      Ch_out     <= ch_out_d;
      Data_valid <= valid_d;
      Frame_done <= frame_d;
    end
  end

endmodule

// File: tb/tb_adc_spi_ctrl.sv
// tb/tb_adc_spi_ctrl.sv - self-checking bench for adc_spi_ctrl with behavioural ADC models

module tb_adc_spi_ctrl;

  localparam int DIV_A = 4;
  localparam int GAP_A = 1000;
  localparam int LAT_A = DIV_A * (2 * (9 + 12) + 2);
  localparam int DIV_B = 2;
  localparam int GAP_B = 10;
  localparam int LAT_B = DIV_B * (2 * (9 + 8) + 2);

  typedef struct {
    int         cyc;
    logic [11:0] data;
    logic [1:0]  ch;
    logic        frame;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic a_en, a_pen, a_dout = 1'b0, a_din, a_dclk, a_cs_n, a_busy, a_valid, a_frame;
  logic [11:0] a_data;
  logic [1:0]  a_ch;
  logic b_en, b_pen, b_dout = 1'b0, b_din, b_dclk, b_cs_n, b_busy, b_valid, b_frame;
  logic [7:0]  b_data;
  logic [1:0]  b_ch;

  adc_spi_ctrl dut_a (
    .CLK(clk), .RST_n(rst_n), .Enable(a_en), .ADC_PENIRQ_n(a_pen), .ADC_DOUT(a_dout),
    .ADC_DIN(a_din), .ADC_DCLK(a_dclk), .ADC_CS_n(a_cs_n), .Busy(a_busy),
    .Data_out(a_data), .Ch_out(a_ch), .Data_valid(a_valid), .Frame_done(a_frame)
  );

  adc_spi_ctrl #(.DATA_W(8), .NUM_CH(1), .CLK_DIV(DIV_B), .GAP_CYC(GAP_B)) dut_b (
    .CLK(clk), .RST_n(rst_n), .Enable(b_en), .ADC_PENIRQ_n(b_pen), .ADC_DOUT(b_dout),
    .ADC_DIN(b_din), .ADC_DCLK(b_dclk), .ADC_CS_n(b_cs_n), .Busy(b_busy),
    .Data_out(b_data), .Ch_out(b_ch), .Data_valid(b_valid), .Frame_done(b_frame)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC models: latch the command on DCLK rises, present the result MSB
  // first after each DCLK fall that follows the busy-bit period.
  logic [11:0] a_val [8];
  logic [7:0]  b_val [8];
  logic [7:0]  a_cmd, b_cmd;
  int a_rise, a_fall, b_rise, b_fall;
  logic [7:0] q_cmd_a [$];
  logic [7:0] q_cmd_b [$];

  always @(negedge a_cs_n) begin a_rise = 0; a_fall = 0; a_cmd = 8'h00; end
  always @(posedge a_dclk) if (!a_cs_n) begin
    a_rise++;
    if (a_rise <= 8) a_cmd = {a_cmd[6:0], a_din};
    if (a_rise == 8) q_cmd_a.push_back(a_cmd);
  end
  always @(negedge a_dclk) if (!a_cs_n) begin
    a_fall++;
    if (a_fall >= 9 && a_fall < 9 + 12) a_dout = a_val[a_cmd[6:4]][20 - a_fall];
    else a_dout = 1'b0;
  end

  always @(negedge b_cs_n) begin b_rise = 0; b_fall = 0; b_cmd = 8'h00; end
  always @(posedge b_dclk) if (!b_cs_n) begin
    b_rise++;
    if (b_rise <= 8) b_cmd = {b_cmd[6:0], b_din};
    if (b_rise == 8) q_cmd_b.push_back(b_cmd);
  end
  always @(negedge b_dclk) if (!b_cs_n) begin
    b_fall++;
    if (b_fall >= 9 && b_fall < 9 + 8) b_dout = b_val[b_cmd[6:4]][16 - b_fall];
    else b_dout = 1'b0;
  end

  // Event logs sampled on the falling clock edge.
  int   q_csf_a [$];
  int   q_csf_b [$];
  ev_t  q_val_a [$];
  ev_t  q_val_b [$];
  logic a_prev_cs = 1'b1, b_prev_cs = 1'b1;
  int   a_bad = 0, b_bad = 0;

  always @(negedge clk) begin
    if (a_prev_cs && !a_cs_n) q_csf_a.push_back(cyc);
    if (b_prev_cs && !b_cs_n) q_csf_b.push_back(cyc);
    a_prev_cs <= a_cs_n;
    b_prev_cs <= b_cs_n;
    if (a_valid) q_val_a.push_back('{cyc, a_data, a_ch, a_frame});
    if (b_valid) q_val_b.push_back('{cyc, 12'(b_data), b_ch, b_frame});
    if ((a_frame && !a_valid) || (a_cs_n && a_dclk)) a_bad <= a_bad + 1;
    if ((b_frame && !b_valid) || (b_cs_n && b_dclk)) b_bad <= b_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sz(input int which);
    case (which)
      0:       return q_csf_a.size();
      1:       return q_val_a.size();
      2:       return q_csf_b.size();
      default: return q_val_b.size();
    endcase
  endfunction

  task automatic wait_sz(input int which, input int n, input int budget, input string tag);
    int k = 0;
    while (sz(which) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(sz(which) >= n), 32'd1);
  endtask

  logic [11:0] exp0, exp1;
  logic [7:0]  b_exp;
  int          r, t;

  initial begin
    a_en = 1'b1; a_pen = 1'b0; b_en = 1'b0; b_pen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_val[i] = 12'($urandom);
      b_val[i] = 8'($urandom);
    end
    a_val[5] = 12'hA5C; a_val[1] = 12'h3F1; b_val[5] = 8'h5A;
    #2 rst_n = 1'b0;
    repeat (5) @(negedge clk);

    chk("rst_cs_n", 32'(a_cs_n), 1);
    chk("rst_dclk", 32'(a_dclk), 0);
    chk("rst_din", 32'(a_din), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_frame", 32'(a_frame), 0);
    chk("rst_data", 32'(a_data), 0);
    chk("rst_ch", 32'(a_ch), 0);
    chk("rst_b_cs_n", 32'(b_cs_n), 1);

    r = cyc;
    rst_n = 1'b1;
    wait_sz(0, 1, 20, "cs_fall_after_rst");
    chk("rst_to_cs_lat", 32'(q_csf_a[0] - r), 3);
    chk("busy_in_frame", 32'(a_busy), 1);

    wait_sz(1, 2, 600, "frame1_strobes");
    chk("cmd_ch0", 32'(q_cmd_a[0]), 32'hD0);
    chk("cmd_ch1", 32'(q_cmd_a[1]), 32'h90);
    chk("lat_ch0", 32'(q_val_a[0].cyc - q_csf_a[0]), LAT_A);
    chk("data_ch0", 32'(q_val_a[0].data), 32'hA5C);
    chk("chout_ch0", 32'(q_val_a[0].ch), 0);
    chk("frame_ch0", 32'(q_val_a[0].frame), 0);
    chk("lat_ch1", 32'(q_val_a[1].cyc - q_csf_a[1]), LAT_A);
    chk("data_ch1", 32'(q_val_a[1].data), 32'h3F1);
    chk("chout_ch1", 32'(q_val_a[1].ch), 1);
    chk("frame_ch1", 32'(q_val_a[1].frame), 1);
    chk("ch_switch", 32'(q_csf_a[1] - q_val_a[0].cyc), DIV_A);

    a_val[5] = 12'($urandom); a_val[1] = 12'($urandom);
    exp0 = a_val[5]; exp1 = a_val[1];
    repeat (10) @(negedge clk);
    chk("busy_in_gap", 32'(a_busy), 0);

    wait_sz(0, 3, 1100, "frame2_start");
    chk("gap_len", 32'(q_csf_a[2] - q_val_a[1].cyc), DIV_A + GAP_A + 1);
    wait_sz(1, 3, 400, "frame2_ch0");
    a_pen = 1'b1;
    wait_sz(1, 4, 400, "frame2_ch1");
    chk("f2_data_ch0", 32'(q_val_a[2].data), 32'(exp0));
    chk("f2_chout_ch0", 32'(q_val_a[2].ch), 0);
    chk("f2_data_ch1", 32'(q_val_a[3].data), 32'(exp1));
    chk("f2_chout_ch1", 32'(q_val_a[3].ch), 1);
    chk("f2_frame", 32'(q_val_a[3].frame), 1);
    repeat (GAP_A + 20) @(negedge clk);
    chk("pen_up_no_frame", 32'(q_csf_a.size()), 4);
    chk("pen_up_busy", 32'(a_busy), 0);

    a_val[5] = 12'($urandom);
    exp0 = a_val[5];
    a_pen = 1'b0;
    wait_sz(0, 5, 20, "en_drop_start");
    repeat (40) @(negedge clk);
    a_en = 1'b0;
    repeat (400) @(negedge clk);
    chk("en_drop_strobes", 32'(q_val_a.size()), 5);
    chk("en_drop_data", 32'(q_val_a[4].data), 32'(exp0));
    chk("en_drop_ch", 32'(q_val_a[4].ch), 0);
    chk("en_drop_frame", 32'(q_val_a[4].frame), 0);
    chk("en_drop_no_ch1", 32'(q_csf_a.size()), 5);
    chk("en_drop_busy", 32'(a_busy), 0);

    a_en = 1'b1;
    wait_sz(0, 6, 20, "rst_abort_start");
    t = q_csf_a[5];
    while (cyc < t + 61) @(negedge clk);
    chk("dclk_high_pre_rst", 32'(a_dclk), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(a_cs_n), 1);
    chk("abort_dclk", 32'(a_dclk), 0);
    chk("abort_busy", 32'(a_busy), 0);
    a_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("abort_no_strobe", 32'(q_val_a.size()), 5);

    b_exp = b_val[5];
    b_pen = 1'b0; b_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_sz(3, k + 1, 200, "b_frame");
      chk("b_lat", 32'(q_val_b[k].cyc - q_csf_b[k]), LAT_B);
      chk("b_data", 32'(q_val_b[k].data), 32'(b_exp));
      chk("b_ch", 32'(q_val_b[k].ch), 0);
      chk("b_frame_done", 32'(q_val_b[k].frame), 1);
      chk("b_cmd", 32'(q_cmd_b[k]), 32'hD8);
      b_val[5] = 8'($urandom);
      b_exp = b_val[5];
    end
    chk("b_gap_len", 32'(q_csf_b[1] - q_val_b[0].cyc), DIV_B + GAP_B + 1);
    b_en = 1'b0;
    repeat (20) @(negedge clk);

    chk("a_pin_rules", 32'(a_bad), 0);
    chk("b_pin_rules", 32'(b_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
